dpram_access_arbiter: RTL

//  Shares one dual_port_sync_ram among NREQ requesters. Each cycle it grants up to two requests,
//  one on RAM port A and one on port B, in round-robin order, and routes read data back to the

---
 rtl/dpram_arb_pkg.sv | 13 +
 rtl/dpram_rr_pick.sv | 27 ++
 rtl/dpram_access_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared defaults and index helper for the dual-port RAM access arbiter.
package dpram_arb_pkg;

  localparam int DPRAM_DW   = 8;
  localparam int DPRAM_AW   = 6;
  localparam int DPRAM_NREQ = 4;
  localparam int DPRAM_IDW  = $clog2(DPRAM_NREQ);

  function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dpram_rr_pick.sv
// Round-robin search: first set bit of valid_i starting at start_i, wrapping modulo N.
module dpram_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int unsigned pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = (32'(start_i) + 32'(k)) % 32'(N);
      if (!found_o && valid_i[IW'(pos)]) begin
        found_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/dpram_access_arbiter.sv
// Two-port round-robin arbiter in front of a dual-port synchronous RAM.
// Optional macro DPRAM_ARB_COLLISION_EN withholds port B on same-address write hazards.
module dpram_access_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DW   = DPRAM_DW,
  parameter int AW   = DPRAM_AW,
  parameter int NREQ = DPRAM_NREQ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [AW-1:0]      addr_a,
  output logic [AW-1:0]      addr_b,
  output logic [DW-1:0]      data_in_a,
  output logic [DW-1:0]      data_in_b,
  output logic               wr_a,
  output logic               wr_b,
  input  logic [DW-1:0]      data_out_a,
  input  logic [DW-1:0]      data_out_b
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]    rr_q, rr_d;
  logic              a_found, b_found, b_ok;
  logic [IDW-1:0]    a_idx, b_idx;
  logic [NREQ-1:0]   b_cand;
  logic [AW-1:0]     a_addr, b_addr;
  logic              a_we, b_we;
  logic              vld_a_q, vld_b_q, vld_a_d, vld_b_d;
  logic [IDW-1:0]    id_a_q, id_b_q;
  logic [NREQ*DW-1:0] rdata_q, rdata_d;

  dpram_rr_pick #(.N(NREQ), .IW(IDW)) u_pick_a (
    .valid_i (req_valid),
    .start_i (rr_q),
    .found_o (a_found),
    .idx_o   (a_idx)
  );

  // B continues the same search with A removed, so it is the next valid after A.
  always_comb begin
    b_cand = req_valid;
    if (a_found) b_cand[a_idx] = 1'b0;
  end

  dpram_rr_pick #(.N(NREQ), .IW(IDW)) u_pick_b (
    .valid_i (b_cand),
    .start_i (rr_q),
    .found_o (b_found),
    .idx_o   (b_idx)
  );

  assign a_addr = req_addr[int'(a_idx)*AW +: AW];
  assign b_addr = req_addr[int'(b_idx)*AW +: AW];
  assign a_we   = req_we[a_idx];
  assign b_we   = req_we[b_idx];

`ifdef DPRAM_ARB_COLLISION_EN
  assign b_ok = b_found && !((a_addr == b_addr) && (a_we || b_we));
`else
  assign b_ok = b_found;
`endif

  // Outputs are forced idle while reset is asserted, independent of the clock.
  always_comb begin
    req_ready = '0;
    addr_a    = '0;
    addr_b    = '0;
    data_in_a = '0;
    data_in_b = '0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    if (rst_n && a_found) begin
      req_ready[a_idx] = 1'b1;
      addr_a           = a_addr;
      data_in_a        = req_wdata[int'(a_idx)*DW +: DW];
      wr_a             = a_we;
    end
    if (rst_n && b_ok) begin
      req_ready[b_idx] = 1'b1;
      addr_b           = b_addr;
      data_in_b        = req_wdata[int'(b_idx)*DW +: DW];
      wr_b             = b_we;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (b_ok)         rr_d = IDW'(idx_inc(32'(b_idx), NREQ));
    else if (a_found) rr_d = IDW'(idx_inc(32'(a_idx), NREQ));
  end

  assign vld_a_d = a_found && !a_we;
  assign vld_b_d = b_ok && !b_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
      id_a_q  <= '0;
      id_b_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      vld_a_q <= vld_a_d;
      vld_b_q <= vld_b_d;
      id_a_q  <= a_idx;
      id_b_q  <= b_idx;
    end
  end

  // RAM data is routed straight through in the response cycle and captured for holding.
  always_comb begin
    rsp_valid = '0;
    rdata_d   = rdata_q;
    for (int i = 0; i < NREQ; i++) begin
      if (vld_a_q && (int'(id_a_q) == i)) begin
        rsp_valid[i]         = 1'b1;
        rdata_d[i*DW +: DW]  = data_out_a;
      end
      if (vld_b_q && (int'(id_b_q) == i)) begin
        rsp_valid[i]         = 1'b1;
        rdata_d[i*DW +: DW]  = data_out_b;
      end
    end
  end

  assign rsp_rdata = rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

endmodule
